// File: rtl/mlp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mlp_ctrl_pkg
//  Purpose  : Shared definitions for the MLP control path (layer sequencer,
//             control pipeline and neuron buffer stages): default widths,
//             MAC pipeline drain depth and the layer-sequencer state encoding.
//  Revision : 1.0  - initial release
// ============================================================================
package mlp_ctrl_pkg;

    // Default neuron/input index width
    localparam int c_ADDR_W    = 12;
    // Default weight memory address width
    localparam int c_WADDR_W   = 16;
    // Default MAC pipeline depth (idle cycles before committing a result)
    localparam int c_DRAIN_CYC = 2;

    // Layer sequencer states, explicitly encoded in three bits
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACCUM = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_counter.sv
`default_nettype none
// ============================================================================
//  Module   : seq_counter
//  Purpose  : Loadable up-counter with enable and a terminal-count flag.
//             Load has priority over enable. at_term compares the current
//             (registered) count against term_val.
//  Ports    : clk      - clock, posedge
//             reset    - synchronous active-high reset, count -> 0
//             load     - load load_val this cycle
//             load_val - value loaded
//             en       - increment this cycle (ignored when load is high)
//             term_val - terminal value for at_term
//             count    - current count
//             at_term  - count == term_val
//  Revision : 1.0  - initial release
// ============================================================================
module seq_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] count,
    output logic             at_term
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count   = r_count;
    assign at_term = (r_count == term_val);

endmodule
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : layer_sequencer
//  Purpose  : Sequences one fully-connected MLP layer through the shared
//             multiply-accumulate unit. Per output neuron: clear the MU,
//             stream input/weight addresses with MAC enables, let the MAC
//             pipeline drain, then commit the neuron. Pulses done at the end.
//  Ports    : clk             - clock, posedge
//             reset           - synchronous active-high reset
//             start           - begin a layer (only honoured in IDLE)
//             cfg_num_in      - inputs per neuron (latched on start)
//             cfg_num_out     - neurons in layer (latched on start)
//             cfg_w_base      - first weight address (latched on start)
//             stall           - memory not ready, freezes accumulation
//             busy            - layer in progress
//             reset_mu        - clear MU accumulator
//             mac_en          - MU accumulates this cycle's operands
//             in_addr         - input activation index
//             weight_addr     - weight memory address
//             write_neuron    - commit MU result
//             out_neuron_addr - neuron index for the write
//             done            - one-cycle layer-complete pulse
//  Revision : 1.0  - initial release
// ============================================================================
module layer_sequencer
    import mlp_ctrl_pkg::*;
#(
    parameter int DRAIN_CYC = c_DRAIN_CYC,  // must be >= 1
    parameter int ADDR_W    = c_ADDR_W,
    parameter int WADDR_W   = c_WADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  cfg_num_in,
    input  logic [ADDR_W-1:0]  cfg_num_out,
    input  logic [WADDR_W-1:0] cfg_w_base,
    input  logic               stall,
    output logic               busy,
    output logic               reset_mu,
    output logic               mac_en,
    output logic [ADDR_W-1:0]  in_addr,
    output logic [WADDR_W-1:0] weight_addr,
    output logic               write_neuron,
    output logic [ADDR_W-1:0]  out_neuron_addr,
    output logic               done
);

    localparam int c_DCNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [c_DCNT_W-1:0] c_DRAIN_LAST = c_DCNT_W'(DRAIN_CYC - 1);

    // ------------------------------------------------------------------------
    // State and latched configuration
    // ------------------------------------------------------------------------
    seq_state_t         r_state;
    seq_state_t         w_state_nxt;

    logic [ADDR_W-1:0]  r_num_in;
    logic [ADDR_W-1:0]  r_num_out;
    logic [WADDR_W-1:0] r_wptr;

    // Registered outputs (in_addr is the input-index counter itself)
    logic               r_busy;
    logic               r_reset_mu;
    logic               r_mac_en;
    logic [WADDR_W-1:0] r_weight_addr;
    logic               r_write_neuron;
    logic [ADDR_W-1:0]  r_out_neuron_addr;
    logic               r_done;

    // Control decoded from the current state
    logic               w_accept;
    logic               w_issue;
    logic               w_i_load;
    logic               w_n_load;
    logic               w_n_en;
    logic               w_d_load;
    logic               w_d_en;

    // Counter views
    logic [ADDR_W-1:0]   w_i_cnt;
    logic                w_i_last;
    logic [ADDR_W-1:0]   w_n_cnt;
    logic                w_n_last;
    logic [c_DCNT_W-1:0] w_drain_cnt_unused;
    logic                w_d_last;

    // ------------------------------------------------------------------------
    // Counters: input index, neuron index, drain cycles.
    // The input counter doubles as in_addr: it is loaded to 0 only on the
    // edge that issues the first MAC, so it holds its last value elsewhere.
    // ------------------------------------------------------------------------
    seq_counter #(.WIDTH(ADDR_W)) u_in_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (w_i_load),
        .load_val ('0),
        .en       (w_issue),
        .term_val (r_num_in - 1'b1),
        .count    (w_i_cnt),
        .at_term  (w_i_last)
    );

    seq_counter #(.WIDTH(ADDR_W)) u_neuron_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (w_n_load),
        .load_val ('0),
        .en       (w_n_en),
        .term_val (r_num_out - 1'b1),
        .count    (w_n_cnt),
        .at_term  (w_n_last)
    );

    seq_counter #(.WIDTH(c_DCNT_W)) u_drain_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (w_d_load),
        .load_val ('0),
        .en       (w_d_en),
        .term_val (c_DRAIN_LAST),
        .count    (w_drain_cnt_unused),
        .at_term  (w_d_last)
    );

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and control. Outputs are registered from the next state, so
    // the decision made in a cycle is visible on the outputs the cycle after.
    // Stall is therefore sampled at the edge that would issue the next MAC;
    // the first MAC of a neuron is issued straight out of CLEAR.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_i_load    = 1'b0;
        w_n_load    = 1'b0;
        w_n_en      = 1'b0;
        w_d_load    = 1'b0;
        w_d_en      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_n_load    = 1'b1;
                    w_state_nxt = (cfg_num_out == '0) ? ST_DONE : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (r_num_in == '0) begin
                    w_d_load    = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_i_load    = 1'b1;
                    w_issue     = 1'b1;
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                // w_i_last means the last index is already on the outputs
                if (w_i_last) begin
                    w_d_load    = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end else if (!stall) begin
                    w_issue     = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_d_last) begin
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_d_en      = 1'b1;
                end
            end
            ST_WRITE: begin
                if (w_n_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_n_en      = 1'b1;
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Configuration latch, weight pointer and registered outputs.
    // The weight pointer runs contiguously across neurons, wrapping modulo
    // 2^WADDR_W, so neuron k starts at w_base + k*num_in.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_num_in          <= '0;
            r_num_out         <= '0;
            r_wptr            <= '0;
            r_busy            <= 1'b0;
            r_reset_mu        <= 1'b0;
            r_mac_en          <= 1'b0;
            r_weight_addr     <= '0;
            r_write_neuron    <= 1'b0;
            r_out_neuron_addr <= '0;
            r_done            <= 1'b0;
        end else begin
            if (w_accept) begin
                r_num_in  <= cfg_num_in;
                r_num_out <= cfg_num_out;
                r_wptr    <= cfg_w_base;
            end else if (w_issue) begin
                r_wptr    <= r_wptr + 1'b1;
            end

            if (w_issue) begin
                r_weight_addr <= r_wptr;
            end

            if (w_state_nxt == ST_WRITE) begin
                r_out_neuron_addr <= w_n_cnt;
            end

            r_busy         <= (w_state_nxt != ST_IDLE);
            r_reset_mu     <= (w_state_nxt == ST_CLEAR);
            r_mac_en       <= w_issue;
            r_write_neuron <= (w_state_nxt == ST_WRITE);
            r_done         <= (w_state_nxt == ST_DONE);
        end
    end

    assign busy            = r_busy;
    assign reset_mu        = r_reset_mu;
    assign mac_en          = r_mac_en;
    assign in_addr         = w_i_cnt;
    assign weight_addr     = r_weight_addr;
    assign write_neuron    = r_write_neuron;
    assign out_neuron_addr = r_out_neuron_addr;
    assign done            = r_done;

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_layer_sequencer
//  Purpose  : Scoreboard bench for layer_sequencer. Stimulus pushes the
//             expected strobe events (cycle, kind, addresses) into a queue;
//             a monitor pops and compares whenever a strobe appears, and
//             checks address hold, busy window and reset values every cycle.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_layer_sequencer;

    localparam int c_ADDR_W  = 12;
    localparam int c_WADDR_W = 16;
    localparam int c_DRAIN   = 2;
    localparam int c_NEVER   = 32'h3FFF_FFFF;

    localparam int K_NONE = 0;
    localparam int K_RMU  = 1;
    localparam int K_MAC  = 2;
    localparam int K_WR   = 3;
    localparam int K_DONE = 4;

    typedef struct {
        int kind;
        int cyc;
        int a;
        int b;
    } ev_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [c_ADDR_W-1:0]  cfg_num_in;
    logic [c_ADDR_W-1:0]  cfg_num_out;
    logic [c_WADDR_W-1:0] cfg_w_base;
    logic                 stall;
    logic                 busy;
    logic                 reset_mu;
    logic                 mac_en;
    logic [c_ADDR_W-1:0]  in_addr;
    logic [c_WADDR_W-1:0] weight_addr;
    logic                 write_neuron;
    logic [c_ADDR_W-1:0]  out_neuron_addr;
    logic                 done;

    ev_t  exp_q[$];
    int   cnt       = 0;
    logic rst_q     = 1'b0;
    int   n_chk     = 0;
    int   n_fail    = 0;
    int   busy_from = 1;
    int   busy_to   = 0;
    bit   final_req = 1'b0;
    bit   mon_done  = 1'b0;

    layer_sequencer #(
        .DRAIN_CYC (c_DRAIN),
        .ADDR_W    (c_ADDR_W),
        .WADDR_W   (c_WADDR_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .cfg_num_in      (cfg_num_in),
        .cfg_num_out     (cfg_num_out),
        .cfg_w_base      (cfg_w_base),
        .stall           (stall),
        .busy            (busy),
        .reset_mu        (reset_mu),
        .mac_en          (mac_en),
        .in_addr         (in_addr),
        .weight_addr     (weight_addr),
        .write_neuron    (write_neuron),
        .out_neuron_addr (out_neuron_addr),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Cycle number of the cycle that follows each rising edge
    always @(posedge clk) begin
        cnt   <= cnt + 1;
        rst_q <= reset;
    end

    function automatic void push(int k, int c, int a, int b);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endfunction

    // Expected events of an unstalled layer started at cycle t0, keeping only
    // events at or before cutoff (a reset at cutoff aborts the rest).
    function automatic void exp_layer(int t0, int nin, int nout, int base, int cutoff);
        int p;
        int done_c;
        p      = nin + c_DRAIN + 2;
        done_c = t0 + nout * p + 1;
        for (int k = 0; k < nout; k++) begin
            int tc;
            tc = t0 + 1 + k * p;
            if (tc <= cutoff) push(K_RMU, tc, 0, 0);
            for (int j = 0; j < nin; j++) begin
                if (tc + 1 + j <= cutoff)
                    push(K_MAC, tc + 1 + j, j, (base + k * nin + j) & 32'hFFFF);
            end
            if (t0 + (k + 1) * p <= cutoff) push(K_WR, t0 + (k + 1) * p, k, 0);
        end
        if (done_c <= cutoff) push(K_DONE, done_c, 0, 0);
        busy_from = t0 + 1;
        busy_to   = (done_c < cutoff) ? done_c : cutoff;
    endfunction

    // Drives one layer for len cycles starting at the current cycle. After
    // cycle 0 the cfg inputs carry junk to show they are not re-sampled.
    task automatic drive(int nin, int nout, int base, int len,
                         int pulse_at, int rst_at, int stall_at, int stall_len);
        for (int c = 0; c < len; c++) begin
            start = (c == 0) || (c == pulse_at);
            if (c == 0) begin
                cfg_num_in  = c_ADDR_W'(nin);
                cfg_num_out = c_ADDR_W'(nout);
                cfg_w_base  = c_WADDR_W'(base);
            end else begin
                cfg_num_in  = 12'h007;
                cfg_num_out = 12'h009;
                cfg_w_base  = 16'hABCD;
            end
            reset = (c == rst_at);
            stall = (c >= stall_at) && (c < stall_at + stall_len);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        reset = 1'b0;
        stall = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    initial begin : monitor
        ev_t e;
        int  kind;
        int  nstb;
        int  hold_in;
        int  hold_w;
        int  hold_out;
        bit  exp_busy;
        hold_in  = 0;
        hold_w   = 0;
        hold_out = 0;
        forever begin
            @(negedge clk);
            if (cnt >= 1 && !mon_done) begin
                if (rst_q) begin
                    n_chk++;
                    if ({busy, reset_mu, mac_en, write_neuron, done} != 5'b0 ||
                        in_addr != '0 || weight_addr != '0 || out_neuron_addr != '0) begin
                        n_fail++;
                        $display("FAIL reset_vals @%0d: busy%0b rmu%0b mac%0b wr%0b done%0b in%0h w%0h out%0h, want all 0",
                                 cnt, busy, reset_mu, mac_en, write_neuron, done,
                                 in_addr, weight_addr, out_neuron_addr);
                    end
                    hold_in  = 0;
                    hold_w   = 0;
                    hold_out = 0;
                end else begin
                    while (exp_q.size() > 0 && exp_q[0].cyc < cnt) begin
                        e = exp_q.pop_front();
                        n_chk++;
                        n_fail++;
                        $display("FAIL missed_event @%0d: got nothing, want kind %0d at cycle %0d",
                                 cnt, e.kind, e.cyc);
                    end

                    nstb = int'(reset_mu) + int'(mac_en) + int'(write_neuron) + int'(done);
                    kind = reset_mu ? K_RMU : mac_en ? K_MAC : write_neuron ? K_WR :
                           done ? K_DONE : K_NONE;

                    if (nstb > 1) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL strobe_excl @%0d: got %0d strobes high, want at most 1", cnt, nstb);
                    end

                    if (kind != K_NONE) begin
                        n_chk++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected @%0d: got kind %0d, want no event", cnt, kind);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.kind != kind || e.cyc != cnt) begin
                                n_fail++;
                                $display("FAIL event @%0d: got kind %0d, want kind %0d at cycle %0d",
                                         cnt, kind, e.kind, e.cyc);
                            end else if (kind == K_MAC &&
                                         (int'(in_addr) != e.a || int'(weight_addr) != e.b)) begin
                                n_fail++;
                                $display("FAIL mac_addr @%0d: got in %0h w %0h, want in %0h w %0h",
                                         cnt, in_addr, weight_addr, e.a, e.b);
                            end else if (kind == K_WR && int'(out_neuron_addr) != e.a) begin
                                n_fail++;
                                $display("FAIL write_addr @%0d: got %0h, want %0h",
                                         cnt, out_neuron_addr, e.a);
                            end
                            if (e.kind == K_MAC) begin
                                hold_in = e.a;
                                hold_w  = e.b;
                            end
                            if (e.kind == K_WR) hold_out = e.a;
                        end
                    end

                    if (!mac_en) begin
                        n_chk++;
                        if (int'(in_addr) != hold_in || int'(weight_addr) != hold_w) begin
                            n_fail++;
                            $display("FAIL addr_hold @%0d: got in %0h w %0h, want in %0h w %0h",
                                     cnt, in_addr, weight_addr, hold_in, hold_w);
                        end
                    end
                    if (!write_neuron) begin
                        n_chk++;
                        if (int'(out_neuron_addr) != hold_out) begin
                            n_fail++;
                            $display("FAIL out_hold @%0d: got %0h, want %0h", cnt, out_neuron_addr, hold_out);
                        end
                    end

                    exp_busy = (cnt >= busy_from) && (cnt <= busy_to);
                    n_chk++;
                    if (busy != exp_busy) begin
                        n_fail++;
                        $display("FAIL busy @%0d: got %0b, want %0b", cnt, busy, exp_busy);
                    end
                end

                if (final_req) begin
                    n_chk++;
                    if (exp_q.size() != 0) begin
                        n_fail++;
                        $display("FAIL leftover: got %0d events never seen, want 0 (first kind %0d cycle %0d)",
                                 exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
                    end
                    mon_done = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin : stimulus
        int t0;
        reset       = 1'b1;
        start       = 1'b0;
        stall       = 1'b0;
        cfg_num_in  = '0;
        cfg_num_out = '0;
        cfg_w_base  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic: 3 inputs, 2 neurons, base 0x100 (P=7, done at 15)
        t0 = cnt;
        exp_layer(t0, 3, 2, 32'h100, c_NEVER);
        drive(3, 2, 32'h100, 16, -1, -1, -1, 0);

        // Same config, stall during relative cycles 2-3 of neuron 0 ACCUM
        t0 = cnt;
        push(K_RMU,  t0 + 1,  0, 0);
        push(K_MAC,  t0 + 2,  0, 32'h100);
        push(K_MAC,  t0 + 5,  1, 32'h101);
        push(K_MAC,  t0 + 6,  2, 32'h102);
        push(K_WR,   t0 + 9,  0, 0);
        push(K_RMU,  t0 + 10, 0, 0);
        push(K_MAC,  t0 + 11, 0, 32'h103);
        push(K_MAC,  t0 + 12, 1, 32'h104);
        push(K_MAC,  t0 + 13, 2, 32'h105);
        push(K_WR,   t0 + 16, 1, 0);
        push(K_DONE, t0 + 17, 0, 0);
        busy_from = t0 + 1;
        busy_to   = t0 + 17;
        drive(3, 2, 32'h100, 18, -1, -1, 2, 2);

        // Start pulsed mid-layer (in ACCUM) with junk cfg: ignored
        t0 = cnt;
        exp_layer(t0, 2, 3, 32'h040, c_NEVER);
        drive(2, 3, 32'h040, 20, 5, -1, -1, 0);

        // Zero neurons: done at cycle 1 only
        t0 = cnt;
        exp_layer(t0, 5, 0, 32'h010, c_NEVER);
        drive(5, 0, 32'h010, 2, -1, -1, -1, 0);

        // Zero inputs, one neuron: reset_mu 1, write 4, done 5
        t0 = cnt;
        exp_layer(t0, 0, 1, 32'h020, c_NEVER);
        drive(0, 1, 32'h020, 6, -1, -1, -1, 0);

        // Reset while in ACCUM (relative cycle 3): rest of layer aborted
        t0 = cnt;
        exp_layer(t0, 3, 2, 32'h200, t0 + 3);
        drive(3, 2, 32'h200, 4, -1, 3, -1, 0);

        // Fresh start right after the abort
        t0 = cnt;
        exp_layer(t0, 1, 2, 32'h300, c_NEVER);
        drive(1, 2, 32'h300, 12, -1, -1, -1, 0);

        // Weight address wrap: 0xFFFE, 0xFFFF, 0x0000, 0x0001
        t0 = cnt;
        exp_layer(t0, 4, 1, 32'hFFFE, c_NEVER);
        drive(4, 1, 32'hFFFE, 10, -1, -1, -1, 0);

        repeat (4) @(posedge clk);
        #1;
        final_req = 1'b1;
        for (int k = 0; k < 10 && !mon_done; k++) @(posedge clk);
        if (!mon_done) begin
            $display("FAIL monitor_timeout: got no final check, want one");
            $fatal(1, "monitor did not complete");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/layer_sequencer.md
# layer_sequencer

Sequences one fully-connected MLP layer through the shared multiply-accumulate unit (MU). For each output neuron it clears the MU, streams input activation/weight addresses with MAC enables, waits for the MAC pipeline to drain, then issues a neuron write. After the last neuron it pulses done. Its outputs drive the registered control pipeline stage in front of the MU and output-neuron memory.

## Interface
- DRAIN_CYC, 2: idle cycles between last MAC enable and write_neuron (MAC pipeline depth)
- ADDR_W, 12: neuron/input index width
- WADDR_W, 16: weight address width
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high; clears all state and outputs
- start  in  1  begin layer; sampled only in IDLE
- cfg_num_in  in  ADDR_W  inputs per neuron; latched on accepted start
- cfg_num_out  in  ADDR_W  neurons in layer; latched on accepted start
- cfg_w_base  in  WADDR_W  first weight address; latched on accepted start
- stall  in  1  memory not ready; freezes ACCUM
- busy  out  1  high from cycle after accepted start through done cycle
- reset_mu  out  1  clear MU accumulator
- mac_en  out  1  MU accumulates this cycle's operands
- in_addr  out  ADDR_W  input activation index
- weight_addr  out  WADDR_W  weight memory address
- write_neuron  out  1  commit MU result
- out_neuron_addr  out  ADDR_W  neuron index for write
- done  out  1  one-cycle layer-complete pulse

## Operation
- States: IDLE, CLEAR, ACCUM, DRAIN, WRITE, DONE.
- IDLE: start -> latch cfg, neuron=0, wptr=cfg_w_base; go CLEAR (or DONE if cfg_num_out==0).
- CLEAR: reset_mu=1 one cycle; i=0; go ACCUM (DRAIN if num_in==0).
- ACCUM: if stall: mac_en=0, in_addr/weight_addr hold. Else mac_en=1, in_addr=i, weight_addr=wptr; i++, wptr++ (mod 2^WADDR_W). After i==num_in-1 issued -> DRAIN.
- DRAIN: DRAIN_CYC cycles, all strobes low; stall ignored -> WRITE.
- WRITE: write_neuron=1, out_neuron_addr=neuron one cycle. neuron==num_out-1 -> DONE, else neuron++ -> CLEAR. wptr continues contiguously (neuron k base = w_base + k*num_in).
- DONE: done=1 one cycle -> IDLE.
- start outside IDLE ignored; cfg changes after latch ignored.
- reset in any state: IDLE immediately, no write_neuron/done emitted for aborted layer.

## Timing
- All outputs registered; reset value 0 for every output, counters, wptr.
- Strobes (reset_mu, mac_en, write_neuron, done) high only in their state; in_addr/weight_addr hold last value outside ACCUM; out_neuron_addr holds last written index.
- start accepted at cycle 0 -> CLEAR in cycle 1.
- No stall: neuron period P = num_in + DRAIN_CYC + 2; neuron k write at cycle (k+1)*P; done at num_out*P + 1; next start accepted at num_out*P + 2.
- Each stall cycle in ACCUM extends that neuron by exactly one cycle.
- num_in==0: P = DRAIN_CYC + 2, no mac_en.

## Structure
- Package mlp_ctrl_pkg: state enum, ADDR_W/WADDR_W defaults, DRAIN_CYC default, shared with pipeline/buffer stages.
- One natural sub-module: seq_counter (loadable, enable, terminal-count flag), instanced for i, neuron, drain count.

## Test plan
- num_in=3, num_out=2, w_base=0x0100, DRAIN_CYC=2, no stall -> reset_mu at 1 and 8; weight_addr 0x100-0x102 then 0x103-0x105; write_neuron at 7 (addr 0) and 14 (addr 1); done at 15.
- Same config, stall high 2 cycles during neuron 0 ACCUM -> mac_en/addresses frozen, neuron 0 write at 9, done at 17.
- num_out=0 -> done at cycle 1, no reset_mu/mac_en/write_neuron; busy only cycle 1.
- num_in=0, num_out=1 -> reset_mu at 1, write at 4, done at 5, mac_en never high.
- start pulsed mid-layer -> ignored; reset at a cycle in ACCUM -> all outputs 0 next cycle, no write/done; fresh start then runs normally.
- w_base=0xFFFE, num_in=4, num_out=1 -> weight_addr 0xFFFE, 0xFFFF, 0x0000, 0x0001.
